// File: rtl/clock_edge_scheduler_if.sv
// Link between one emulated-clock edge scheduler and the time manager:
// edge-spacing controls and committed time in, candidate time and clock state out.
interface clock_edge_scheduler_if #(
  parameter int unsigned TIME_WIDTH   = 32,
  parameter int unsigned PERIOD_WIDTH = 24,
  parameter int unsigned JITTER_WIDTH = 12
);
  logic                    en;
  logic [PERIOD_WIDTH-1:0] half_period;
  logic [JITTER_WIDTH-1:0] jitter;
  logic [TIME_WIDTH-1:0]   time_curr;
  logic [TIME_WIDTH-1:0]   time_next;
  logic                    clk_out;
  logic                    edge_pulse;
  logic [15:0]             edge_count;
  logic                    err_missed;
  logic                    err_sat;

  // Time manager / controller side
  modport master (
    output en, half_period, jitter, time_curr,
    input  time_next, clk_out, edge_pulse, edge_count, err_missed, err_sat
  );

  // Scheduler side
  modport slave (
    input  en, half_period, jitter, time_curr,
    output time_next, clk_out, edge_pulse, edge_count, err_missed, err_sat
  );
endinterface

// File: rtl/clock_edge_scheduler.sv
// Event source for one emulated clock domain: holds the emulated time of the
// next edge, offers it to the time manager, toggles the emulated clock when
// committed time reaches it, and reschedules half a period (plus jitter) later.
module clock_edge_scheduler #(
  parameter int unsigned           TIME_WIDTH   = 32,
  parameter int unsigned           PERIOD_WIDTH = 24,
  parameter int unsigned           JITTER_WIDTH = 12,
  parameter logic [TIME_WIDTH-1:0] INIT_OFFSET  = '0
) (
  input logic                    clk,
  input logic                    rst,
  clock_edge_scheduler_if.slave  bus
);

  logic [TIME_WIDTH-1:0]   sched;
  logic signed [PERIOD_WIDTH:0] step_raw;
  logic                    step_clamp;
  logic [PERIOD_WIDTH-1:0] step;
  logic [TIME_WIDTH:0]     sum;
  logic                    sat_carry;
  logic [TIME_WIDTH-1:0]   sched_plus;
  logic                    fire;

  // Next-edge arithmetic, fire decision and candidate time, all same-cycle
  always_comb begin
    step_raw   = $signed({1'b0, bus.half_period})
               + $signed({{(PERIOD_WIDTH + 1 - JITTER_WIDTH){bus.jitter[JITTER_WIDTH-1]}}, bus.jitter});
    // Zero or negative spacing would let the same time re-fire; force at least 1
    step_clamp = step_raw[PERIOD_WIDTH] || (step_raw == '0);
    step       = step_clamp ? {{(PERIOD_WIDTH-1){1'b0}}, 1'b1} : step_raw[PERIOD_WIDTH-1:0];
    sum        = {1'b0, sched} + {{(TIME_WIDTH + 1 - PERIOD_WIDTH){1'b0}}, step};
    sat_carry  = sum[TIME_WIDTH];
    sched_plus = sat_carry ? '1 : sum[TIME_WIDTH-1:0];
    fire       = bus.en && !bus.err_sat && (bus.time_curr >= sched);

    if (!bus.en || bus.err_sat) begin
      bus.time_next = '1;
    end else if (fire) begin
      bus.time_next = sched_plus;
    end else begin
      bus.time_next = sched;
    end
  end

  // Schedule, emulated clock level, edge pulse/count and sticky errors
  always_ff @(posedge clk) begin
    if (rst) begin
      sched          <= INIT_OFFSET;
      bus.clk_out    <= 1'b0;
      bus.edge_pulse <= 1'b0;
      bus.edge_count <= '0;
      bus.err_missed <= 1'b0;
      bus.err_sat    <= 1'b0;
    end else if (fire) begin
      sched          <= sched_plus;
      bus.clk_out    <= ~bus.clk_out;
      bus.edge_pulse <= 1'b1;
      bus.edge_count <= bus.edge_count + 16'd1;
      if (bus.time_curr > sched) begin
        bus.err_missed <= 1'b1;
      end
      if (sat_carry) begin
        bus.err_sat <= 1'b1;
      end
    end else begin
      bus.edge_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clock_edge_scheduler.sv
// Self-checking bench for clock_edge_scheduler: expectations are queued when
// each cycle's stimulus is driven and compared once the DUT has produced them.
module tb_clock_edge_scheduler;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  clock_edge_scheduler_if #(.TIME_WIDTH(32), .PERIOD_WIDTH(24), .JITTER_WIDTH(12)) bus ();

  clock_edge_scheduler #(
    .TIME_WIDTH  (32),
    .PERIOD_WIDTH(24),
    .JITTER_WIDTH(12),
    .INIT_OFFSET (32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [31:0] val;
  } exp_t;

  localparam int unsigned SEL_TN   = 0;
  localparam int unsigned SEL_CLK  = 1;
  localparam int unsigned SEL_EP   = 2;
  localparam int unsigned SEL_CNT  = 3;
  localparam int unsigned SEL_MISS = 4;
  localparam int unsigned SEL_SAT  = 5;

  exp_t        comb_q[$];
  exp_t        reg_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic        exp_clk;
  logic [15:0] exp_cnt;

  function automatic logic [31:0] observe(input int unsigned sel);
    case (sel)
      SEL_TN:   return bus.time_next;
      SEL_CLK:  return {31'b0, bus.clk_out};
      SEL_EP:   return {31'b0, bus.edge_pulse};
      SEL_CNT:  return {16'b0, bus.edge_count};
      SEL_MISS: return {31'b0, bus.err_missed};
      SEL_SAT:  return {31'b0, bus.err_sat};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit is_comb, input string tag, input int unsigned sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    if (is_comb) comb_q.push_back(e);
    else         reg_q.push_back(e);
  endtask

  task automatic drain_comb();
    exp_t e;
    while (comb_q.size() > 0) begin
      e = comb_q.pop_front();
      check_val(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic drain_reg();
    exp_t e;
    while (reg_q.size() > 0) begin
      e = reg_q.pop_front();
      check_val(e.tag, observe(e.sel), e.val);
    end
  endtask

  // One emulator cycle: drive inputs, check time_next, clock, check registers.
  // fire/miss/sat describe what the spec says this cycle must do.
  task automatic run_cycle(input string tag, input logic r, input logic e,
                           input logic [23:0] hp, input logic [11:0] jit,
                           input logic [31:0] tc, input logic fire,
                           input logic [31:0] tn, input logic miss, input logic sat);
    rst             = r;
    bus.en          = e;
    bus.half_period = hp;
    bus.jitter      = jit;
    bus.time_curr   = tc;
    push_exp(1'b1, {tag, "/time_next"}, SEL_TN, tn);
    if (r) begin
      exp_clk = 1'b0;
      exp_cnt = '0;
    end else if (fire) begin
      exp_clk = ~exp_clk;
      exp_cnt = exp_cnt + 16'd1;
    end
    push_exp(1'b0, {tag, "/clk_out"},    SEL_CLK,  {31'b0, exp_clk});
    push_exp(1'b0, {tag, "/edge_pulse"}, SEL_EP,   {31'b0, fire & ~r});
    push_exp(1'b0, {tag, "/edge_count"}, SEL_CNT,  {16'b0, exp_cnt});
    push_exp(1'b0, {tag, "/err_missed"}, SEL_MISS, {31'b0, miss & ~r});
    push_exp(1'b0, {tag, "/err_sat"},    SEL_SAT,  {31'b0, sat & ~r});
    #1;
    drain_comb();
    @(posedge clk);
    #1;
    drain_reg();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [31:0] tc;
    exp_clk = 1'b0;
    exp_cnt = '0;

    // Reset with en low: candidate is all-ones, registers at reset values
    run_cycle("reset", 1'b1, 1'b0, 24'd10, 12'd0, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Closed loop: time_curr follows time_next one cycle later, fires every cycle
    tc = 32'd0;
    for (int k = 0; k < 8; k++) begin
      run_cycle("run", 1'b0, 1'b1, 24'd10, 12'd0, tc, 1'b1, tc + 32'd10, 1'b0, 1'b0);
      tc = tc + 32'd10;
    end

    // Jitter: -15 and -10 clamp the advance to 1; +3 stretches to 13
    run_cycle("jit_neg",  1'b0, 1'b1, 24'd10, 12'hFF1, 32'd80, 1'b1, 32'd81, 1'b0, 1'b0);
    run_cycle("jit_zero", 1'b0, 1'b1, 24'd10, 12'hFF6, 32'd81, 1'b1, 32'd82, 1'b0, 1'b0);
    run_cycle("jit_pos",  1'b0, 1'b1, 24'd10, 12'd3,   32'd82, 1'b1, 32'd95, 1'b0, 1'b0);

    // Time short of schedule: no fire; then overshoot: late fire sets err_missed
    run_cycle("early0", 1'b0, 1'b1, 24'd10, 12'd0, 32'd90,  1'b0, 32'd95,  1'b0, 1'b0);
    run_cycle("early1", 1'b0, 1'b1, 24'd10, 12'd0, 32'd90,  1'b0, 32'd95,  1'b0, 1'b0);
    run_cycle("late",   1'b0, 1'b1, 24'd10, 12'd0, 32'd100, 1'b1, 32'd105, 1'b1, 1'b0);
    run_cycle("on_time",1'b0, 1'b1, 24'd10, 12'd0, 32'd105, 1'b1, 32'd115, 1'b1, 1'b0);
    run_cycle("no_refire", 1'b0, 1'b1, 24'd10, 12'd0, 32'd105, 1'b0, 32'd115, 1'b1, 1'b0);

    // Disabled for 5 cycles: quiet and frozen, then resumes from held schedule
    for (int k = 0; k < 5; k++) begin
      run_cycle("en_off", 1'b0, 1'b0, 24'd10, 12'd0, 32'd500, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    end
    run_cycle("resume", 1'b0, 1'b1, 24'd10, 12'd0, 32'd115, 1'b1, 32'd125, 1'b1, 1'b0);

    // Reset on a fire cycle wins; then restarts from INIT_OFFSET
    run_cycle("rst_fire", 1'b1, 1'b1, 24'd10, 12'd0, 32'd125, 1'b1, 32'd135, 1'b0, 1'b0);
    run_cycle("post_rst", 1'b0, 1'b1, 24'd10, 12'd0, 32'd0,   1'b1, 32'd10,  1'b0, 1'b0);

    // Climb to 0xFFFFFFF0 with maximal half periods, then overflow the schedule
    tc = 32'd10;
    for (int k = 0; k < 256; k++) begin
      run_cycle("climb", 1'b0, 1'b1, 24'hFF_FFFF, 12'd0, tc, 1'b1, tc + 32'h00FF_FFFF, 1'b0, 1'b0);
      tc = tc + 32'h00FF_FFFF;
    end
    run_cycle("climb_end", 1'b0, 1'b1, 24'h00_00E6, 12'd0, tc, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0);
    run_cycle("sat", 1'b0, 1'b1, 24'h00_0020, 12'd0, 32'hFFFF_FFF0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      run_cycle("quiet", 1'b0, 1'b1, 24'd10, 12'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    end

    // Only reset clears the saturation error
    run_cycle("rst_clear", 1'b1, 1'b1, 24'd10, 12'd0, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_cycle("after_clr", 1'b0, 1'b1, 24'd10, 12'd0, 32'd0, 1'b1, 32'd10,        1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
